// File: rtl/mac_pkg.sv
// Shared definitions for the MAC layer sequencer: datapath widths, the
// sequencer state encoding and the optional ReLU capture helper.
package mac_pkg;

  localparam int DATA_W = 8;   // input / weight / bias element width
  localparam int ACC_W  = 16;  // accumulator and result width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_OUTPUT = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Negative results collapse to zero, positive ones pass through.
  function automatic logic [ACC_W-1:0] relu_f(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] r;
    if (v[ACC_W-1]) begin
      r = {ACC_W{1'b0}};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Address generation for the MAC layer sequencer: k counter for the input
// RAM, row-major weight address (weight base + k), neuron counter that also
// drives the bias RAM, and the last-input / last-neuron flags used by the FSM.
module mac_seq_addr_gen #(
  parameter  int MAX_LEN  = 16,
  parameter  int MAX_NEUR = 16,
  parameter  int WADDR_W  = 8,
  localparam int LEN_W    = $clog2(MAX_LEN + 1),
  localparam int NEUR_W   = $clog2(MAX_NEUR + 1),
  localparam int DADDR_W  = $clog2(MAX_LEN),
  localparam int BADDR_W  = $clog2(MAX_NEUR)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,        // layer accepted: restart from neuron 0
  input  logic               clear,       // per-neuron restart of k
  input  logic               step,        // one (input, weight) pair issued
  input  logic               advance,     // neuron result accepted downstream
  input  logic [LEN_W-1:0]   len,         // latched K
  input  logic [NEUR_W-1:0]  neur,        // latched N
  output logic [DADDR_W-1:0] data_addr,
  output logic [WADDR_W-1:0] weight_addr,
  output logic [BADDR_W-1:0] bias_addr,
  output logic               last_k,
  output logic               last_neur
);

  logic [LEN_W-1:0]   k_r;
  logic [WADDR_W-1:0] waddr_r;
  logic [WADDR_W-1:0] wbase_r;
  logic [NEUR_W-1:0]  neuron_r;

  // Counter state: k / weight address walk a row, base and neuron step per accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      k_r      <= {LEN_W{1'b0}};
      waddr_r  <= {WADDR_W{1'b0}};
      wbase_r  <= {WADDR_W{1'b0}};
      neuron_r <= {NEUR_W{1'b0}};
    end else if (load) begin
      k_r      <= {LEN_W{1'b0}};
      waddr_r  <= {WADDR_W{1'b0}};
      wbase_r  <= {WADDR_W{1'b0}};
      neuron_r <= {NEUR_W{1'b0}};
    end else begin
      if (clear) begin
        k_r     <= {LEN_W{1'b0}};
        waddr_r <= wbase_r;
      end else if (step) begin
        k_r     <= k_r + LEN_W'(1);
        waddr_r <= waddr_r + WADDR_W'(1);
      end
      if (advance) begin
        neuron_r <= neuron_r + NEUR_W'(1);
        wbase_r  <= wbase_r + WADDR_W'(len);
      end
    end
  end

  // Flags and address views of the counters; k reaching K only occurs after
  // the last issue, so truncating it onto the RAM address is harmless.
  always_comb begin
    last_k      = (k_r == (len - LEN_W'(1)));
    last_neur   = (neuron_r == (neur - NEUR_W'(1)));
    data_addr   = k_r[DADDR_W-1:0];
    weight_addr = waddr_r;
    bias_addr   = neuron_r[BADDR_W-1:0];
  end

endmodule

// File: rtl/mac_layer_sequencer.sv
// Sequences one external MAC datapath through a fully-connected layer.
// For each neuron: clear accumulator, stream K (input, weight) pairs from
// sync-read RAMs, let the bias settle, capture the result and hand it off
// over valid/ready. Optional build macro MAC_SEQ_RELU_EN applies ReLU to the
// captured result; without it the signed result passes unmodified.
module mac_layer_sequencer
  import mac_pkg::*;
#(
  parameter  int MAX_LEN  = 16,
  parameter  int MAX_NEUR = 16,
  parameter  int WADDR_W  = 8,
  localparam int LEN_W    = $clog2(MAX_LEN + 1),
  localparam int NEUR_W   = $clog2(MAX_NEUR + 1),
  localparam int DADDR_W  = $clog2(MAX_LEN),
  localparam int BADDR_W  = $clog2(MAX_NEUR)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   len_in,
  input  logic [NEUR_W-1:0]  neur_in,
  output logic [DADDR_W-1:0] data_addr,
  output logic [WADDR_W-1:0] weight_addr,
  output logic [BADDR_W-1:0] bias_addr,
  output logic               mac_enable,
  output logic               mac_clear,
  input  logic [ACC_W-1:0]   mac_result,
  output logic [ACC_W-1:0]   out_data,
  output logic [BADDR_W-1:0] out_index,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [LEN_W-1:0]    len_r;
  logic [NEUR_W-1:0]   neur_r;
  logic [LEN_W-1:0]    len_clamp_s;
  logic [NEUR_W-1:0]   neur_clamp_s;
  logic                load_s;
  logic                clear_s;
  logic                step_s;
  logic                advance_s;
  logic                last_k_s;
  logic                last_neur_s;
  logic [ACC_W-1:0]    capture_s;
  logic [ACC_W-1:0]    out_data_r;
  logic [BADDR_W-1:0]  out_index_r;
  logic                out_valid_r;
  logic                mac_enable_r;
  logic                mac_clear_r;
  logic                busy_r;
  logic                done_r;

  mac_seq_addr_gen #(
    .MAX_LEN  (MAX_LEN),
    .MAX_NEUR (MAX_NEUR),
    .WADDR_W  (WADDR_W)
  ) u_addr_gen (
    .clock       (clock),
    .reset       (reset),
    .load        (load_s),
    .clear       (clear_s),
    .step        (step_s),
    .advance     (advance_s),
    .len         (len_r),
    .neur        (neur_r),
    .data_addr   (data_addr),
    .weight_addr (weight_addr),
    .bias_addr   (bias_addr),
    .last_k      (last_k_s),
    .last_neur   (last_neur_s)
  );

  // Oversized layer dimensions are clamped to the supported maximum.
  always_comb begin
    if (len_in > LEN_W'(MAX_LEN)) begin
      len_clamp_s = LEN_W'(MAX_LEN);
    end else begin
      len_clamp_s = len_in;
    end
    if (neur_in > NEUR_W'(MAX_NEUR)) begin
      neur_clamp_s = NEUR_W'(MAX_NEUR);
    end else begin
      neur_clamp_s = neur_in;
    end
  end

  // Result shaping at capture time; adds no latency.
  always_comb begin
`ifdef MAC_SEQ_RELU_EN
    capture_s = relu_f(mac_result);
`else
    capture_s = mac_result;
`endif
  end

  // Next-state decode and one-cycle strobes to the address generator.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    clear_s     = 1'b0;
    step_s      = 1'b0;
    advance_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s = 1'b1;
          if (neur_clamp_s == {NEUR_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CLEAR;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clear_s = 1'b1;
        // A zero-length row has nothing to issue: the result is the bias alone.
        if (len_r == {LEN_W{1'b0}}) begin
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        step_s = 1'b1;
        if (last_k_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        state_nxt_s = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_nxt_s = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          advance_s = 1'b1;
          if (last_neur_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CLEAR;
          end
        end else begin
          state_nxt_s = ST_OUTPUT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register plus the layer dimensions latched when a start is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      len_r   <= {LEN_W{1'b0}};
      neur_r  <= {NEUR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        len_r  <= len_clamp_s;
        neur_r <= neur_clamp_s;
      end
    end
  end

  // Registered control outputs; mac_enable trails each issue by the RAM latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      mac_enable_r <= 1'b0;
      mac_clear_r  <= 1'b0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      mac_enable_r <= (state_r == ST_ISSUE);
      mac_clear_r  <= (state_nxt_s == ST_CLEAR);
      out_valid_r  <= (state_nxt_s == ST_OUTPUT);
      busy_r       <= (state_nxt_s != ST_IDLE);
      done_r       <= (state_nxt_s == ST_DONE);
    end
  end

  // Result capture at the end of SETTLE; held stable for the whole handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_r  <= {ACC_W{1'b0}};
      out_index_r <= {BADDR_W{1'b0}};
    end else if (state_r == ST_SETTLE) begin
      out_data_r  <= capture_s;
      out_index_r <= bias_addr;
    end
  end

  assign out_data   = out_data_r;
  assign out_index  = out_index_r;
  assign out_valid  = out_valid_r;
  assign mac_enable = mac_enable_r;
  assign mac_clear  = mac_clear_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule
